// File: rtl/i2c_byte_master_pkg.sv
// Shared state and command encodings for the I2C byte master engine.
package i2c_byte_master_pkg;

    typedef enum logic [3:0] {
        k_idle   = 4'd0,
        k_start1 = 4'd1,
        k_start2 = 4'd2,
        k_start3 = 4'd3,
        k_start4 = 4'd4,
        k_data1  = 4'd5,
        k_data2  = 4'd6,
        k_data3  = 4'd7,
        k_data4  = 4'd8,
        k_hold   = 4'd9,
        k_stop1  = 4'd10,
        k_stop2  = 4'd11,
        k_stop3  = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        k_cmd_start = 2'd0,
        k_cmd_write = 2'd1,
        k_cmd_read  = 2'd2,
        k_cmd_stop  = 2'd3
    } cmd_e;

    localparam logic [3:0] LAST_BIT = 4'd8;

    // States in which a slave may stretch SCL by holding it low after release.
    function automatic logic is_stretch_state(input state_e s);
        return (s == k_start2) || (s == k_data2) || (s == k_stop2);
    endfunction

endpackage

// File: rtl/i2c_byte_master_timer.sv
// Quarter-period timer: latches the divisor on command accept and flags the
// last cycle of each quarter, freezing while a slave stretches SCL.
module i2c_quarter_timer #(
    parameter int CTR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [CTR_WIDTH-1:0] divisor_i,
    input  logic                 run_i,
    input  logic                 hold_i,
    output logic                 tc_o
);

    logic [CTR_WIDTH-1:0] div_q, div_d;
    logic [CTR_WIDTH-1:0] ctr_q, ctr_d;

    assign tc_o = run_i && !hold_i && (ctr_q == div_q);

    always_comb begin
        div_d = div_q;
        ctr_d = ctr_q;
        if (load_i) begin
            div_d = divisor_i;
            ctr_d = '0;
        end else if (run_i && !hold_i) begin
            ctr_d = tc_o ? '0 : ctr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            ctr_q <= '0;
        end else begin
            div_q <= div_d;
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: sequences START/WRITE/READ/STOP as quarter-period bus
// states and returns the sampled byte and ACK slot.
module i2c_byte_master
    import i2c_byte_master_pkg::*;
#(
    parameter int CTR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CTR_WIDTH-1:0] clock_divisor,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd,
    input  logic [7:0]           tx_data,
    input  logic                 master_nack,
    output logic                 rsp_valid,
    output logic                 rsp_error,
    output logic [7:0]           rx_data,
    output logic                 ack_out,
    input  logic                 sda_in,
    input  logic                 scl_in,
    output logic                 sda_out,
    output logic                 scl_out,
    output logic                 data_phase
);

    state_e     state_q, state_d;
    logic [8:0] tx_q, tx_d;
    logic [8:0] rx_q, rx_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       ack_q, ack_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_error_q, rsp_error_d;
    logic       accept, tc;

    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rx_data   = rx_data_q;
    assign ack_out   = ack_q;

    i2c_quarter_timer #(.CTR_WIDTH(CTR_WIDTH)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .divisor_i (clock_divisor),
        .run_i     ((state_q != k_idle) && (state_q != k_hold)),
        .hold_i    (is_stretch_state(state_q) && !scl_in),
        .tc_o      (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= k_idle;
            tx_q        <= 9'h1FF;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            ack_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        ack_d       = ack_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        case (state_q)
            k_idle: begin
                // Only START is meaningful off-bus; anything else is consumed and flagged.
                if (accept) begin
                    if (cmd_e'(cmd) == k_cmd_start) begin
                        state_d = k_start1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end
                end
            end
            k_hold: begin
                if (accept) begin
                    case (cmd_e'(cmd))
                        k_cmd_start: state_d = k_start1;
                        k_cmd_write: begin
                            tx_d      = {tx_data, 1'b1};
                            bit_cnt_d = '0;
                            state_d   = k_data1;
                        end
                        k_cmd_read: begin
                            tx_d      = {8'hFF, master_nack};
                            bit_cnt_d = '0;
                            state_d   = k_data1;
                        end
                        default: state_d = k_stop1;
                    endcase
                end
            end
            k_start1: if (tc) state_d = k_start2;
            k_start2: if (tc) state_d = k_start3;
            k_start3: if (tc) state_d = k_start4;
            k_start4: begin
                if (tc) begin
                    state_d     = k_hold;
                    rsp_valid_d = 1'b1;
                end
            end
            k_data1: if (tc) state_d = k_data2;
            k_data2: begin
                if (tc) begin
                    state_d = k_data3;
                    rx_d    = {rx_q[7:0], sda_in};
                end
            end
            k_data3: if (tc) state_d = k_data4;
            k_data4: begin
                if (tc) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d     = k_hold;
                        rx_data_d   = rx_q[8:1];
                        ack_d       = rx_q[0];
                        rsp_valid_d = 1'b1;
                    end else begin
                        tx_d      = {tx_q[7:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = k_data1;
                    end
                end
            end
            k_stop1: if (tc) state_d = k_stop2;
            k_stop2: if (tc) state_d = k_stop3;
            k_stop3: begin
                if (tc) begin
                    state_d     = k_idle;
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = k_idle;
        endcase
    end

    always_comb begin
        scl_out    = 1'b1;
        sda_out    = 1'b1;
        cmd_ready  = 1'b0;
        data_phase = 1'b0;
        case (state_q)
            k_idle:   cmd_ready = 1'b1;
            k_start1: scl_out = 1'b0;
            k_start2: ;
            k_start3: sda_out = 1'b0;
            k_start4: begin scl_out = 1'b0; sda_out = 1'b0; end
            k_data1:  begin scl_out = 1'b0; sda_out = tx_q[8]; data_phase = 1'b1; end
            k_data2:  begin sda_out = tx_q[8]; data_phase = 1'b1; end
            k_data3:  begin sda_out = tx_q[8]; data_phase = 1'b1; end
            k_data4:  begin scl_out = 1'b0; sda_out = tx_q[8]; data_phase = 1'b1; end
            k_hold:   begin scl_out = 1'b0; cmd_ready = 1'b1; end
            k_stop1:  begin scl_out = 1'b0; sda_out = 1'b0; end
            k_stop2:  sda_out = 1'b0;
            k_stop3:  ;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master: wired-AND bus with a byte-level
// slave model, directed scenarios plus randomized byte traffic.
module tb_i2c_byte_master;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] clock_divisor = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd = '0;
    logic [7:0]  tx_data = '0;
    logic        master_nack = 1'b0;
    logic        rsp_valid, rsp_error;
    logic [7:0]  rx_data;
    logic        ack_out;
    logic        sda_in, scl_in, sda_out, scl_out, data_phase;

    int checks = 0;
    int failures = 0;

    // Bus and slave model state
    logic       slaveActive = 1'b0;
    logic [8:0] slavePattern = 9'h1FF;
    logic       slaveSda;
    logic [8:0] slaveShift;
    int         fallBase = 0;
    int         fallCount = 0;
    int         startConds = 0;
    int         stopConds = 0;
    logic       riseBits[$];
    logic       prevScl = 1'b1;
    logic       prevSda = 1'b1;
    logic       stretchArm = 1'b0;
    logic       stretchUsed = 1'b0;
    logic       stretchLow = 1'b0;
    int         stretchLen = 0;
    int         stretchCnt = 0;
    logic [7:0] expRx = 8'h00;
    logic       expAck = 1'b1;

    always #5 clk = ~clk;

    i2c_byte_master #(.CTR_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .clock_divisor (clock_divisor),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd           (cmd),
        .tx_data       (tx_data),
        .master_nack   (master_nack),
        .rsp_valid     (rsp_valid),
        .rsp_error     (rsp_error),
        .rx_data       (rx_data),
        .ack_out       (ack_out),
        .sda_in        (sda_in),
        .scl_in        (scl_in),
        .sda_out       (sda_out),
        .scl_out       (scl_out),
        .data_phase    (data_phase)
    );

    // The slave presents bit k of its pattern after the k-th SCL fall of the byte.
    always_comb begin
        slaveSda   = 1'b1;
        slaveShift = '0;
        if (slaveActive && (fallCount - fallBase) >= 0 && (fallCount - fallBase) < 9) begin
            slaveShift = slavePattern >> (8 - (fallCount - fallBase));
            slaveSda   = slaveShift[0];
        end
    end

    assign sda_in = sda_out & slaveSda;
    assign scl_in = scl_out & ~stretchLow;

    always @(negedge clk) begin
        if (data_phase && scl_out && !prevScl) riseBits.push_back(sda_out);
        if (data_phase && !scl_out && prevScl) fallCount++;
        if (scl_out && prevScl && prevSda && !sda_out) startConds++;
        if (scl_out && prevScl && !prevSda && sda_out) stopConds++;
        prevScl = scl_out;
        prevSda = sda_out;
    end

    // One-shot SCL stretch at the first high phase of an armed byte.
    always @(negedge clk) begin
        if (stretchCnt > 0) begin
            stretchCnt--;
            if (stretchCnt == 0) stretchLow = 1'b0;
        end else if (stretchArm && !stretchUsed && data_phase && scl_out) begin
            stretchUsed = 1'b1;
            stretchLow  = 1'b1;
            stretchCnt  = stretchLen;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic [7:0] data, input logic nack,
                                 input int div, input bit waitRsp, output int lat);
        @(negedge clk);
        checkOutput("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_valid     = 1'b1;
        cmd           = c;
        tx_data       = data;
        master_nack   = nack;
        clock_divisor = 16'(div);
        @(posedge clk);
        #1;
        cmd_valid     = 1'b0;
        clock_divisor = 16'($urandom_range(0, 15));
        tx_data       = 8'($urandom);
        master_nack   = 1'($urandom);
        lat = 0;
        if (waitRsp) begin
            while (rsp_valid !== 1'b1 && lat < 4000) begin
                @(posedge clk);
                #1;
                lat++;
            end
            if (rsp_valid !== 1'b1) checkOutput("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
        end
    endtask

    task automatic startOp(input int div, input string tag);
        int lat;
        applyStimulus(CMD_START, 8'h00, 1'b0, div, 1'b1, lat);
        checkOutput({tag, "_lat"}, lat, 4 * (div + 1));
        checkOutput({tag, "_err"}, {31'd0, rsp_error}, 32'd0);
        checkOutput({tag, "_hold_bus"}, {30'd0, scl_out, sda_out}, 32'b01);
        checkOutput({tag, "_rx_kept"}, {23'd0, ack_out, rx_data}, {23'd0, expAck, expRx});
    endtask

    task automatic stopOp(input int div, input string tag);
        int lat;
        applyStimulus(CMD_STOP, 8'h00, 1'b0, div, 1'b1, lat);
        checkOutput({tag, "_lat"}, lat, 3 * (div + 1));
        checkOutput({tag, "_err"}, {31'd0, rsp_error}, 32'd0);
        checkOutput({tag, "_idle_bus"}, {29'd0, cmd_ready, scl_out, sda_out}, 32'b111);
        checkOutput({tag, "_rx_kept"}, {23'd0, ack_out, rx_data}, {23'd0, expAck, expRx});
    endtask

    task automatic byteOp(input bit isRead, input logic [7:0] data, input logic nack,
                          input logic [7:0] slvByte, input logic slvAck, input int div,
                          input int stretch, input string tag);
        logic [8:0] mbits, bus, got;
        int lat, rb;
        mbits        = isRead ? {8'hFF, nack} : {data, 1'b1};
        slavePattern = isRead ? {slvByte, 1'b1} : {8'hFF, slvAck};
        fallBase     = fallCount;
        rb           = riseBits.size();
        slaveActive  = 1'b1;
        if (stretch > 0) begin
            stretchLen = stretch;
            stretchArm = 1'b1;
        end
        applyStimulus(isRead ? CMD_READ : CMD_WRITE, data, nack, div, 1'b1, lat);
        slaveActive = 1'b0;
        stretchArm  = 1'b0;
        bus    = mbits & slavePattern;
        expRx  = bus[8:1];
        expAck = bus[0];
        checkOutput({tag, "_lat"}, lat, 36 * (div + 1) + stretch);
        checkOutput({tag, "_err"}, {31'd0, rsp_error}, 32'd0);
        checkOutput({tag, "_rx"}, {24'd0, rx_data}, {24'd0, expRx});
        checkOutput({tag, "_ack"}, {31'd0, ack_out}, {31'd0, expAck});
        checkOutput({tag, "_scl_pulses"}, riseBits.size() - rb, 9);
        got = '0;
        for (int i = 0; i < 9; i++) begin
            if (rb + i < riseBits.size()) got = {got[7:0], riseBits[rb + i]};
        end
        checkOutput({tag, "_sda_bits"}, {23'd0, got}, {23'd0, mbits});
    endtask

    initial begin
        int lat, d, sBase, pBase;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_bus", {30'd0, scl_out, sda_out}, 32'b11);
        checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("reset_rsp", {30'd0, rsp_valid, rsp_error}, 32'd0);
        checkOutput("reset_rx", {24'd0, rx_data}, 32'd0);
        checkOutput("reset_ack", {31'd0, ack_out}, 32'd1);
        checkOutput("reset_data_phase", {31'd0, data_phase}, 32'd0);

        $display("[TB] illegal WRITE from idle");
        applyStimulus(CMD_WRITE, 8'h5A, 1'b0, 2, 1'b1, lat);
        checkOutput("illegal_lat", lat, 0);
        checkOutput("illegal_err", {31'd0, rsp_error}, 32'd1);
        checkOutput("illegal_bus", {30'd0, scl_out, sda_out}, 32'b11);
        @(posedge clk);
        #1;
        checkOutput("illegal_pulse_end", {31'd0, rsp_valid}, 32'd0);
        checkOutput("illegal_ready", {31'd0, cmd_ready}, 32'd1);

        $display("[TB] D=3 WRITE A5, D=1 READ 3C with NACK");
        startOp(3, "start_d3");
        byteOp(1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 3, 0, "write_a5");
        byteOp(1'b1, 8'h00, 1'b1, 8'h3C, 1'b1, 1, 0, "read_3c");
        stopOp(1, "stop_d1");

        $display("[TB] SCL stretch of 10 cycles");
        startOp(3, "start_str");
        byteOp(1'b0, 8'($urandom), 1'b0, 8'h00, 1'($urandom), 3, 10, "write_stretch");
        stopOp(3, "stop_str");

        $display("[TB] repeated start at D=0");
        sBase = startConds;
        pBase = stopConds;
        startOp(0, "rs_start1");
        byteOp(1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0, 0, 0, "rs_write");
        startOp(0, "rs_start2");
        stopOp(0, "rs_stop");
        checkOutput("rs_start_conds", startConds - sBase, 2);
        checkOutput("rs_stop_conds", stopConds - pBase, 1);
        applyStimulus(CMD_READ, 8'h00, 1'b0, 0, 1'b1, lat);
        checkOutput("rs_ends_idle_err", {31'd0, rsp_error}, 32'd1);

        $display("[TB] randomized byte traffic");
        for (int n = 0; n < 5; n++) begin
            d = $urandom_range(0, 3);
            startOp(d, "rnd_start");
            for (int k = 0; k < 2; k++) begin
                byteOp(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                       d, 0, "rnd_byte");
            end
            stopOp(d, "rnd_stop");
        end

        $display("[TB] reset in the middle of a data quarter");
        startOp(3, "rst_start");
        applyStimulus(CMD_WRITE, 8'h81, 1'b0, 3, 1'b0, lat);
        checkOutput("rst_ready_drop", {31'd0, cmd_ready}, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("rst_in_data_high", {30'd0, data_phase, scl_out}, 32'b11);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_bus", {30'd0, scl_out, sda_out}, 32'b11);
        checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_data_phase", {31'd0, data_phase}, 32'd0);
        checkOutput("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
